// File: rtl/seven_seg_pkg.sv
// Shared seven-segment definitions: active-low glyphs for hex digits 0-F,
// the blank and idle patterns, and the capture FSM state encoding. The
// encoder side uses the same glyph table, through hex_to_glyph.
package seven_seg_pkg;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] GLYPH_0 = 7'b1000000;
    localparam logic [6:0] GLYPH_1 = 7'b1111001;
    localparam logic [6:0] GLYPH_2 = 7'b0100100;
    localparam logic [6:0] GLYPH_3 = 7'b0110000;
    localparam logic [6:0] GLYPH_4 = 7'b0011001;
    localparam logic [6:0] GLYPH_5 = 7'b0010010;
    localparam logic [6:0] GLYPH_6 = 7'b0000010;
    localparam logic [6:0] GLYPH_7 = 7'b1111000;
    localparam logic [6:0] GLYPH_8 = 7'b0000000;
    localparam logic [6:0] GLYPH_9 = 7'b0010000;
    localparam logic [6:0] GLYPH_A = 7'b0001000;
    localparam logic [6:0] GLYPH_B = 7'b0000011;
    localparam logic [6:0] GLYPH_C = 7'b1000110;
    localparam logic [6:0] GLYPH_D = 7'b0100001;
    localparam logic [6:0] GLYPH_E = 7'b0000110;
    localparam logic [6:0] GLYPH_F = 7'b0001110;

    // Element i of this packed table is the glyph for hex value i
    localparam logic [15:0][6:0] GLYPHS = {
        GLYPH_F, GLYPH_E, GLYPH_D, GLYPH_C,
        GLYPH_B, GLYPH_A, GLYPH_9, GLYPH_8,
        GLYPH_7, GLYPH_6, GLYPH_5, GLYPH_4,
        GLYPH_3, GLYPH_2, GLYPH_1, GLYPH_0
    };

    // All segments off, and no anode driven
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] AN_IDLE   = 4'b1111;

    // Capture FSM states
    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_TRACK = 2'd1,
        ST_HOLD  = 2'd2
    } capture_state_t;

    // Encoder-side helper: hex digit to active-low glyph
    function automatic logic [6:0] hex_to_glyph(input logic [3:0] hex);
        return GLYPHS[hex];
    endfunction

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational glyph-to-hex decoder. Patterns that are not one of the
// sixteen standard glyphs, including blank, decode as invalid with hex 0.
module seven_seg_decode
    import seven_seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] hex,
    output logic       valid
);

    // Search the glyph table; the glyphs are distinct, so at most one matches
    always_comb begin
        hex   = 4'd0;
        valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (seg == GLYPHS[i]) begin
                hex   = 4'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seven_seg_capture.sv
// Recovers the four hex digits shown on a multiplexed active-low seven-segment
// display by watching its anode and cathode pins. A digit is accepted once
// the same (anode, segments) pair has been seen STABLE_CYCLES times in a row;
// a pulse marks each completed frame of four accepted digits.
module seven_seg_capture
    import seven_seg_pkg::*;
#(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  an,
    input  logic [6:0]  seg,
    output logic [15:0] value,
    output logic [3:0]  digit_ok,
    output logic        frame_valid,
    output logic        multi_err,
    output logic        stale
);

    localparam logic [3:0]  STABLE_W  = 4'(STABLE_CYCLES);
    localparam logic [19:0] TIMEOUT_W = 20'(TIMEOUT_CYCLES);

    logic [3:0]     an_q;
    logic [6:0]     seg_q;
    logic           sample_active;
    logic           sample_multi;
    logic [1:0]     sample_idx;
    capture_state_t state;
    logic [1:0]     cur_idx;
    logic [6:0]     cur_seg;
    logic [3:0]     count;
    logic           same_pair;
    logic [3:0]     next_count;
    logic           accept;
    logic [3:0]     dec_hex;
    logic           dec_valid;
    logic [3:0]     seen;
    logic [3:0]     seen_next;
    logic [19:0]    timer;
    logic [19:0]    timer_next;

    seven_seg_decode u_decode (
        .seg   (seg_q),
        .hex   (dec_hex),
        .valid (dec_valid)
    );

    // Register the display pins once; every decision uses this copy
    always_ff @(posedge clk) begin
        if (reset) begin
            an_q  <= AN_IDLE;
            seg_q <= SEG_BLANK;
        end else begin
            an_q  <= an;
            seg_q <= seg;
        end
    end

    // Classify the sample as one active digit, idle, or several anodes low
    always_comb begin
        sample_active = 1'b0;
        sample_multi  = 1'b0;
        sample_idx    = 2'd0;
        case (an_q)
            4'b1110: begin sample_active = 1'b1; sample_idx = 2'd0; end
            4'b1101: begin sample_active = 1'b1; sample_idx = 2'd1; end
            4'b1011: begin sample_active = 1'b1; sample_idx = 2'd2; end
            4'b0111: begin sample_active = 1'b1; sample_idx = 2'd3; end
            AN_IDLE: sample_multi = 1'b0;
            default: sample_multi = 1'b1;
        endcase
    end

    // Compare with the pair being tracked and decide whether this edge accepts
    always_comb begin
        same_pair  = (state != ST_WAIT) && sample_active &&
                     (sample_idx == cur_idx) && (seg_q == cur_seg);
        next_count = (state == ST_TRACK && same_pair) ? count + 4'd1 : 4'd1;
        accept     = sample_active && !(state == ST_HOLD && same_pair) &&
                     (next_count == STABLE_W);
        seen_next  = seen | (4'b0001 << sample_idx);
        timer_next = accept ? 20'd0 :
                     (timer >= TIMEOUT_W) ? timer : timer + 20'd1;
    end

    // Stability FSM: a pair must repeat before it is accepted, once per run
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_WAIT;
            cur_idx <= 2'd0;
            cur_seg <= SEG_BLANK;
            count   <= 4'd0;
        end else begin
            case (state)
                ST_WAIT: begin
                    if (sample_active) begin
                        cur_idx <= sample_idx;
                        cur_seg <= seg_q;
                        count   <= next_count;
                        state   <= accept ? ST_HOLD : ST_TRACK;
                    end
                end
                ST_TRACK: begin
                    if (!sample_active) begin
                        count <= 4'd0;
                        state <= ST_WAIT;
                    end else begin
                        cur_idx <= sample_idx;
                        cur_seg <= seg_q;
                        count   <= next_count;
                        state   <= accept ? ST_HOLD : ST_TRACK;
                    end
                end
                ST_HOLD: begin
                    if (!sample_active) begin
                        count <= 4'd0;
                        state <= ST_WAIT;
                    end else if (!same_pair) begin
                        cur_idx <= sample_idx;
                        cur_seg <= seg_q;
                        count   <= next_count;
                        state   <= accept ? ST_HOLD : ST_TRACK;
                    end
                end
                default: begin
                    count <= 4'd0;
                    state <= ST_WAIT;
                end
            endcase
        end
    end

    // Write accepted digits, track which positions are filled, flag frames
    always_ff @(posedge clk) begin
        if (reset) begin
            value       <= 16'd0;
            digit_ok    <= 4'd0;
            seen        <= 4'd0;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            if (accept) begin
                value[{sample_idx, 2'b00} +: 4] <= dec_valid ? dec_hex : 4'd0;
                digit_ok[sample_idx]            <= dec_valid;
                if (seen_next == 4'b1111) begin
                    seen        <= 4'd0;
                    frame_valid <= 1'b1;
                end else begin
                    seen <= seen_next;
                end
            end
        end
    end

    // Sticky error when several anodes are low at once
    always_ff @(posedge clk) begin
        if (reset) begin
            multi_err <= 1'b0;
        end else if (sample_multi) begin
            multi_err <= 1'b1;
        end
    end

    // Saturating count of cycles since the last accept; an accept always wins
    always_ff @(posedge clk) begin
        if (reset) begin
            timer <= 20'd0;
            stale <= 1'b0;
        end else begin
            timer <= timer_next;
            stale <= (timer_next >= TIMEOUT_W);
        end
    end

endmodule

// File: tb/tb_seven_seg_capture.sv
// Self-checking bench for seven_seg_capture: a table of single-digit
// presentations with expected outputs, plus hand-written sequences for
// back-to-back frames, latency, multi-anode errors, timeout and reset.
module tb_seven_seg_capture;

    logic        clk;
    logic        reset;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [15:0] value;
    logic [3:0]  digit_ok;
    logic        frame_valid;
    logic        multi_err;
    logic        stale;

    int errors;
    int checks;
    int frame_cnt;

    typedef struct {
        logic [3:0]  an;
        logic [6:0]  seg;
        int          hold;
        logic [15:0] value;
        logic [3:0]  ok;
        int          frames;
    } vec_t;

    vec_t vecs [15];

    seven_seg_capture #(
        .STABLE_CYCLES  (4),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .an          (an),
        .seg         (seg),
        .value       (value),
        .digit_ok    (digit_ok),
        .frame_valid (frame_valid),
        .multi_err   (multi_err),
        .stale       (stale)
    );

    // Free-running clock, 10 time units per cycle
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every cycle in which the frame pulse is high
    initial frame_cnt = 0;
    always @(negedge clk) begin
        if (frame_valid === 1'b1) frame_cnt++;
    end

    // Advance one clock and settle just after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a pin pair for a number of cycles
    task automatic applyStimulus(input logic [3:0] a, input logic [6:0] s, input int n);
        an  = a;
        seg = s;
        repeat (n) tick();
    endtask

    // Compare one observed value with its expectation
    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One-cycle synchronous reset with the display idle
    task automatic doReset();
        an    = 4'b1111;
        seg   = 7'b1111111;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int base;
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        an     = 4'b1111;
        seg    = 7'b1111111;

        vecs[0]  = '{4'b1110, 7'b0000000, 3, 16'h0000, 4'b0000, 0};
        vecs[1]  = '{4'b1110, 7'b0010010, 4, 16'h0005, 4'b0001, 0};
        vecs[2]  = '{4'b1101, 7'b0001000, 4, 16'h00A5, 4'b0011, 0};
        vecs[3]  = '{4'b1011, 7'b1111110, 4, 16'h00A5, 4'b0011, 0};
        vecs[4]  = '{4'b1110, 7'b0000011, 6, 16'h00AB, 4'b0011, 0};
        vecs[5]  = '{4'b0111, 7'b0001110, 4, 16'hF0AB, 4'b1011, 1};
        vecs[6]  = '{4'b1011, 7'b0100001, 4, 16'hFDAB, 4'b1111, 1};
        vecs[7]  = '{4'b1110, 7'b1000110, 2, 16'hFDAB, 4'b1111, 1};
        vecs[8]  = '{4'b1101, 7'b0000110, 4, 16'hFDEB, 4'b1111, 1};
        vecs[9]  = '{4'b1110, 7'b0011001, 4, 16'hFDE4, 4'b1111, 1};
        vecs[10] = '{4'b0111, 7'b1111000, 4, 16'h7DE4, 4'b1111, 2};
        vecs[11] = '{4'b1101, 7'b0000010, 4, 16'h7D64, 4'b1111, 2};
        vecs[12] = '{4'b1011, 7'b0010000, 4, 16'h7964, 4'b1111, 2};
        vecs[13] = '{4'b0111, 7'b0000000, 4, 16'h8964, 4'b1111, 2};
        vecs[14] = '{4'b1110, 7'b0100100, 4, 16'h8962, 4'b1111, 3};

        repeat (2) tick();
        reset = 1'b0;

        $display("[TB] reset state");
        checkOutput("reset value", value, 16'h0000);
        checkOutput("reset digit_ok", {12'd0, digit_ok}, 16'h0000);
        checkOutput("reset frame_valid", {15'd0, frame_valid}, 16'h0000);
        checkOutput("reset multi_err", {15'd0, multi_err}, 16'h0000);
        checkOutput("reset stale", {15'd0, stale}, 16'h0000);

        $display("[TB] back-to-back frame 3210");
        doReset();
        base = frame_cnt;
        applyStimulus(4'b1110, 7'b1000000, 4);
        applyStimulus(4'b1101, 7'b1111001, 4);
        applyStimulus(4'b1011, 7'b0100100, 4);
        checkOutput("b2b no early frame", 16'(frame_cnt - base), 16'd0);
        applyStimulus(4'b0111, 7'b0110000, 4);
        checkOutput("b2b frame not before last accept", 16'(frame_cnt - base), 16'd0);
        applyStimulus(4'b1111, 7'b1111111, 2);
        checkOutput("b2b one frame", 16'(frame_cnt - base), 16'd1);
        checkOutput("b2b value", value, 16'h3210);
        checkOutput("b2b digit_ok", {12'd0, digit_ok}, 16'h000F);
        applyStimulus(4'b1111, 7'b1111111, 4);
        checkOutput("b2b no extra frame", 16'(frame_cnt - base), 16'd1);

        $display("[TB] vector table");
        doReset();
        base = frame_cnt;
        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].an, vecs[i].seg, vecs[i].hold);
            applyStimulus(4'b1111, 7'b1111111, 2);
            checkOutput($sformatf("vec%0d value", i), value, vecs[i].value);
            checkOutput($sformatf("vec%0d digit_ok", i), {12'd0, digit_ok}, {12'd0, vecs[i].ok});
            checkOutput($sformatf("vec%0d frames", i), 16'(frame_cnt - base), 16'(vecs[i].frames));
            checkOutput($sformatf("vec%0d multi_err", i), {15'd0, multi_err}, 16'h0000);
        end

        $display("[TB] acceptance latency");
        doReset();
        applyStimulus(4'b0111, 7'b0110000, 4);
        checkOutput("latency not yet", value, 16'h0000);
        tick();
        checkOutput("latency update", value, 16'h3000);
        checkOutput("latency digit_ok", {12'd0, digit_ok}, 16'h0008);
        applyStimulus(4'b1111, 7'b1111111, 2);

        $display("[TB] multiple anodes low");
        doReset();
        applyStimulus(4'b1100, 7'b1111001, 1);
        checkOutput("multi one edge", {15'd0, multi_err}, 16'h0000);
        applyStimulus(4'b1111, 7'b1111111, 1);
        checkOutput("multi two edges", {15'd0, multi_err}, 16'h0001);
        applyStimulus(4'b1111, 7'b1111111, 4);
        checkOutput("multi no nibble", value, 16'h0000);
        checkOutput("multi no digit_ok", {12'd0, digit_ok}, 16'h0000);
        applyStimulus(4'b1110, 7'b1111001, 4);
        applyStimulus(4'b1111, 7'b1111111, 2);
        checkOutput("multi held", {15'd0, multi_err}, 16'h0001);
        checkOutput("multi later digit", value, 16'h0001);
        doReset();
        checkOutput("multi cleared", {15'd0, multi_err}, 16'h0000);

        $display("[TB] timeout");
        doReset();
        applyStimulus(4'b1111, 7'b1111111, 49);
        checkOutput("stale at 49", {15'd0, stale}, 16'h0000);
        tick();
        checkOutput("stale at 50", {15'd0, stale}, 16'h0001);
        applyStimulus(4'b1110, 7'b1000000, 4);
        checkOutput("stale before accept", {15'd0, stale}, 16'h0001);
        tick();
        checkOutput("stale after accept", {15'd0, stale}, 16'h0000);
        checkOutput("stale accept digit_ok", {12'd0, digit_ok}, 16'h0001);
        applyStimulus(4'b1111, 7'b1111111, 2);

        $display("[TB] reset mid-frame");
        doReset();
        base = frame_cnt;
        applyStimulus(4'b1110, 7'b1000000, 4);
        applyStimulus(4'b1111, 7'b1111111, 2);
        applyStimulus(4'b1101, 7'b1111001, 4);
        applyStimulus(4'b1111, 7'b1111111, 2);
        checkOutput("partial value", value, 16'h0010);
        doReset();
        checkOutput("post-reset value", value, 16'h0000);
        checkOutput("post-reset digit_ok", {12'd0, digit_ok}, 16'h0000);
        checkOutput("post-reset frame_valid", {15'd0, frame_valid}, 16'h0000);
        checkOutput("post-reset stale", {15'd0, stale}, 16'h0000);
        applyStimulus(4'b0111, 7'b0011001, 4);
        applyStimulus(4'b1111, 7'b1111111, 2);
        applyStimulus(4'b1011, 7'b0010010, 4);
        applyStimulus(4'b1111, 7'b1111111, 2);
        applyStimulus(4'b1101, 7'b0000010, 4);
        applyStimulus(4'b1111, 7'b1111111, 2);
        checkOutput("no frame after three", 16'(frame_cnt - base), 16'd0);
        applyStimulus(4'b1110, 7'b1111000, 4);
        applyStimulus(4'b1111, 7'b1111111, 2);
        checkOutput("frame after four", 16'(frame_cnt - base), 16'd1);
        checkOutput("fresh frame value", value, 16'h4567);

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seven_seg_capture.md
SEVEN_SEG_CAPTURE -- requirements
Module: seven_seg_capture

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4: consecutive identical samples needed to accept a digit, range 1..15.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000000: cycles without an accepted digit before stale asserts, range 2..2^20-1.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port an, input, 4: multiplexed digit anodes, active-low; an[0] is the rightmost digit.
REQ-006 SHALL have port seg, input, 7: segment cathodes, active-low, {g,f,e,d,c,b,a} = seg[6:0].
REQ-007 SHALL have port value, output, 16: captured digits; nibble i = digit i.
REQ-008 SHALL have port digit_ok, output, 4: bit i = 1 when digit i decoded to a valid hex glyph.
REQ-009 SHALL have port frame_valid, output, 1: one-cycle pulse when a complete 4-digit frame is captured.
REQ-010 SHALL have port multi_err, output, 1: sticky flag for more than one anode low.
REQ-011 SHALL have port stale, output, 1: no digit accepted for TIMEOUT_CYCLES.

Function
REQ-012 SHALL register an/seg once on input (1-cycle sample stage); all decisions use the registered copy.
REQ-013 SHALL classify each sample: exactly one an bit low gives active index 0..3; an = 4'b1111 gives idle; two or more low gives a multi sample.
REQ-014 SHALL, on a multi sample, set multi_err (held until reset), treat the sample as idle and discard it.
REQ-015 SHALL decode seg to hex 0-F using the standard glyphs (0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110); any other pattern, including blank 1111111, gives invalid.
REQ-016 SHALL use a three-state FSM:
 - WAIT: idle sample; go to TRACK on an active sample and load count=1.
 - TRACK: same (index, seg) increments count; a different active pair reloads count=1; idle returns to WAIT; accept when count reaches STABLE_CYCLES, then go to HOLD.
 - HOLD: same pair stays in HOLD with no re-accept; a different active pair goes to TRACK with count=1; idle goes to WAIT.
REQ-017 SHALL, on accept, write nibble[index] = decoded value (0 if invalid), set digit_ok[index] = valid, and set seen[index].
REQ-018 SHALL allow re-accepting a digit before the frame completes; the newest value overwrites, and seen is unchanged.
REQ-019 SHALL, at the edge where seen becomes 4'b1111, pulse frame_valid for one cycle and clear seen to 0 at the same edge; value and digit_ok hold until overwritten.
REQ-020 SHALL give acceptance latency of STABLE_CYCLES+1 cycles from the first pin-level cycle of a stable pair to the output update.
REQ-021 SHALL count cycles since the last accept, saturating; stale = 1 when count >= TIMEOUT_CYCLES.
REQ-022 SHALL, when an accept and a timeout occur on the same cycle, let the accept win: timer cleared, stale = 0 next cycle.

Reset
REQ-023 SHALL reset to: value=0, digit_ok=0, frame_valid=0, multi_err=0, stale=0, seen=0, FSM=WAIT, counters=0, sample regs an=4'b1111 and seg=7'b1111111.
REQ-024 SHALL, on reset mid-frame, discard partial frames; frame_valid requires four fresh accepts afterwards.

Structure
REQ-025 SHALL put the 16 glyph constants, FSM state encodings and the blank pattern in a shared package/include seven_seg_pkg, also used by the encoder side.
REQ-026 SHALL place glyph-to-hex decoding in a combinational sub-module seven_seg_decode (in: seg[6:0]; out: hex[3:0], valid).

Verification
REQ-027 SHALL cover this case with STABLE_CYCLES=4: an=1110/seg=1000000, 1101/1111001, 1011/0100100, 0111/0110000, each for 4 cycles -> exactly one frame_valid pulse, value=16'h3210, digit_ok=4'b1111.
REQ-028 SHALL cover this case: an=1110/seg=0000000 for only 3 cycles, then an=1111 -> no accept; value, digit_ok and seen unchanged.
REQ-029 SHALL cover this case: an=1100 for 1 cycle -> multi_err=1 two edges later and held through later valid traffic until reset; no nibble written.
REQ-030 SHALL cover this case: a full frame with digit 2 stable at seg=1111110 -> frame_valid pulse, digit_ok=4'b1011, value[11:8]=0.
REQ-031 SHALL cover this case with TIMEOUT_CYCLES=50 and an=1111: stale=1 once the counter reaches 50; then a stable digit 0 -> stale=0 the cycle after the accept.
REQ-032 SHALL cover this case: 2 digits accepted, then reset for 1 cycle, then the full 4-digit sequence -> all outputs zero after reset; exactly one frame_valid, and only after all four new digits.
